// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Run/step/breakpoint sequencer for the 4-bit nibble processor.
//               Generates the fetch/execute phase, the global datapath enable
//               (cpu_en) and a retired-instruction counter. Free-run, single
//               step, halt-at-boundary and PC breakpoints with one-shot resume
//               are supported.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run_btn,
   input  logic             step_btn,
   input  logic             halt_btn,
   input  logic             bp_en,
   input  logic [11:0]      bp_addr,
   input  logic [11:0]      pc,
   output logic             phase,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   // Encoding is visible on the state port, so values are fixed explicitly.
   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_BRK  = 2'b11
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             phase_q;
   logic             phase_d;
   logic             skip_q;
   logic             skip_d;
   logic             run_q;
   logic             step_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   logic             run_rise;
   logic             step_rise;
   logic             bp_hit;
   logic             enable;
   logic             boundary;

   // Button edges, breakpoint match and the datapath qualifier.
   // bp_hit looks at pc combinationally so the breakpointed fetch itself is
   // suppressed; skip masks the match once after a resume so that the
   // instruction sitting at bp_addr can actually execute.
   always_comb begin
      run_rise  = run_btn & ~run_q;
      step_rise = step_btn & ~step_q;
      bp_hit    = bp_en & (state_q == ST_RUN) & ~phase_q
                  & (pc == bp_addr) & ~skip_q;
      enable    = (state_q == ST_STEP) | ((state_q == ST_RUN) & ~bp_hit);
      boundary  = enable & phase_q;
   end

   // Next-state, phase, skip and counter logic.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      skip_d  = skip_q;
      count_d = count_q;

      // The first enabled fetch after a resume consumes the skip.
      if (enable & ~phase_q) begin
         skip_d = 1'b0;
      end

      unique case (state_q)
         ST_HALT: begin
            // Step takes priority when both buttons rise together.
            if (step_rise) begin
               state_d = ST_STEP;
            end else if (run_rise & ~halt_btn) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Halt is only honoured at an instruction boundary.
            if (bp_hit) begin
               state_d = ST_BRK;
            end else if (boundary & halt_btn) begin
               state_d = ST_HALT;
            end
         end
         ST_STEP: begin
            // Breakpoints, halt and buttons are ignored for the whole step.
            if (boundary) begin
               state_d = ST_HALT;
            end
         end
         ST_BRK: begin
            if (halt_btn) begin
               state_d = ST_HALT;
            end else if (step_rise) begin
               state_d = ST_STEP;
            end else if (run_rise) begin
               state_d = ST_RUN;
               skip_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase

      // Phase advances only with the datapath; in HALT/BRK it rests at fetch
      // because every exit from RUN/STEP into them happens on a boundary or
      // on a suppressed fetch.
      if (enable) begin
         phase_d = ~phase_q;
      end

      if (boundary) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // State register; reset discards any partially executed instruction.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_HALT;
         phase_q <= 1'b0;
         skip_q  <= 1'b0;
         run_q   <= 1'b0;
         step_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         skip_q  <= skip_d;
         run_q   <= run_btn;
         step_q  <= step_btn;
         count_q <= count_d;
      end
   end

   // Output mapping.
   always_comb begin
      phase       = phase_q;
      cpu_en      = enable;
      state       = state_q;
      halted      = (state_q == ST_HALT) | (state_q == ST_BRK);
      instr_count = count_q;
   end

endmodule
`default_nettype wire
